twos_comp_arbiter: RTL and testbench

Shares one 6-bit two's-complement negation unit (~x + 1) between two requesters and sequences multi-step operations through it.
Supported operations are NEG, ABS, SUB (A + (−B)) and PASS, with round-robin arbitration, valid/ready handshakes and a held response register.
It sits between the small arithmetic clients and the response consumer in the Assignment 1 datapath.

---
 rtl/twos_comp_arbiter_if.sv | 40 ++++
 rtl/twos_comp_arbiter.sv | 165 ++++++++++++++++
 tb/tb_twos_comp_arbiter.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/twos_comp_arbiter_if.sv
// Request/response bundle for twos_comp_arbiter: two requester channels,
// one held response channel and the busy flag.
interface twos_comp_arbiter_if #(
    parameter int W = 6
);
    logic         req0_valid;
    logic         req0_ready;
    logic [1:0]   req0_op;
    logic [W-1:0] req0_a;
    logic [W-1:0] req0_b;

    logic         req1_valid;
    logic         req1_ready;
    logic [1:0]   req1_op;
    logic [W-1:0] req1_a;
    logic [W-1:0] req1_b;

    logic         rsp_valid;
    logic         rsp_ready;
    logic         rsp_id;
    logic [W-1:0] rsp_data;
    logic         rsp_ovf;
    logic         busy;

    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        output req1_valid, req1_op, req1_a, req1_b,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_data, rsp_ovf, busy
    );

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        input  req1_valid, req1_op, req1_a, req1_b,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_data, rsp_ovf, busy
    );
endinterface

// File: rtl/twos_comp_arbiter.sv
// Two-requester round-robin front end around one shared ~x+1 negation unit.
// Define SATURATE_EN to clamp overflowing results instead of wrapping them.
module twos_comp_arbiter #(
    parameter int W = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    twos_comp_arbiter_if.slave    bus
);
    typedef enum logic [1:0] {S_IDLE, S_EXEC1, S_EXEC2, S_RESP} state_t;

    localparam logic [1:0] OP_NEG  = 2'b00;
    localparam logic [1:0] OP_ABS  = 2'b01;
    localparam logic [1:0] OP_SUB  = 2'b10;
    localparam logic [1:0] OP_PASS = 2'b11;

    localparam logic signed [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};
    localparam logic signed [W-1:0] ONE     = W'(1);

`ifdef SATURATE_EN
    function automatic logic signed [W-1:0] saturate(
        input logic signed [W-1:0] wrap,
        input logic                ovf,
        input logic                neg_side
    );
        if (!ovf) return wrap;
        return neg_side ? MIN_VAL : {1'b0, {(W-1){1'b1}}};
    endfunction
`endif

    state_t              r_state;
    logic                r_ptr;
    logic                r_id;
    logic [1:0]          r_op;
    logic signed [W-1:0] r_a;
    logic signed [W-1:0] r_b;
    logic signed [W-1:0] r_nb;
    logic signed [W-1:0] r_data;
    logic                r_ovf;

    state_t              w_next;
    logic                w_rdy0;
    logic                w_rdy1;
    logic                w_accept;
    logic                w_grant;
    logic                w_load;
    logic signed [W-1:0] w_unit_in;
    logic signed [W-1:0] w_unit_out;
    logic signed [W-1:0] w_sum;
    logic signed [W-1:0] w_wrap;
    logic signed [W-1:0] w_res;
    logic                w_ovf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Ready is combinational in IDLE; rst gates it so nothing is offered while reset is held.
    always_comb begin
        w_next   = r_state;
        w_rdy0   = 1'b0;
        w_rdy1   = 1'b0;
        w_accept = 1'b0;
        w_grant  = 1'b0;
        w_load   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!rst && (bus.req0_valid || bus.req1_valid)) begin
                    w_accept = 1'b1;
                    w_grant  = (bus.req0_valid && bus.req1_valid) ? r_ptr : bus.req1_valid;
                    w_rdy0   = !w_grant;
                    w_rdy1   = w_grant;
                    w_next   = S_EXEC1;
                end
            end
            S_EXEC1: begin
                if (r_op == OP_SUB) begin
                    w_next = S_EXEC2;
                end else begin
                    w_load = 1'b1;
                    w_next = S_RESP;
                end
            end
            S_EXEC2: begin
                w_load = 1'b1;
                w_next = S_RESP;
            end
            S_RESP: begin
                if (bus.rsp_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // The single negation unit sees B during the first SUB step, A otherwise.
    always_comb begin
        w_unit_in  = (r_op == OP_SUB) ? r_b : r_a;
        w_unit_out = ~w_unit_in + ONE;
        w_sum      = r_a + r_nb;
    end

    always_comb begin
        w_wrap = r_a;
        w_ovf  = 1'b0;
        if (r_state == S_EXEC2) begin
            w_wrap = w_sum;
            // -MIN_VAL wraps back to MIN_VAL, so judge that case on the true difference.
            if (r_b == MIN_VAL) w_ovf = !r_a[W-1];
            else                w_ovf = (r_a[W-1] == r_nb[W-1]) && (w_sum[W-1] != r_a[W-1]);
        end else begin
            case (r_op)
                OP_NEG: begin
                    w_wrap = w_unit_out;
                    w_ovf  = (r_a == MIN_VAL);
                end
                OP_ABS: begin
                    w_wrap = r_a[W-1] ? w_unit_out : r_a;
                    w_ovf  = (r_a == MIN_VAL);
                end
                default: w_wrap = r_a;
            endcase
        end
`ifdef SATURATE_EN
        w_res = saturate(w_wrap, w_ovf, (r_state == S_EXEC2) && r_a[W-1]);
`else
        w_res = w_wrap;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr  <= 1'b0;
            r_id   <= 1'b0;
            r_data <= '0;
            r_ovf  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_ptr <= !w_grant;
                r_id  <= w_grant;
            end
            if (w_load) begin
                r_data <= w_res;
                r_ovf  <= w_ovf;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_op <= w_grant ? bus.req1_op : bus.req0_op;
            r_a  <= w_grant ? bus.req1_a  : bus.req0_a;
            r_b  <= w_grant ? bus.req1_b  : bus.req0_b;
        end
        if (r_state == S_EXEC1 && r_op == OP_SUB) r_nb <= w_unit_out;
    end

    assign bus.req0_ready = w_rdy0;
    assign bus.req1_ready = w_rdy1;
    assign bus.rsp_valid  = (r_state == S_RESP);
    assign bus.busy       = (r_state != S_IDLE);
    assign bus.rsp_id     = r_id;
    assign bus.rsp_data   = r_data;
    assign bus.rsp_ovf    = r_ovf;
endmodule

// File: tb/tb_twos_comp_arbiter.sv
// Scoreboard bench for twos_comp_arbiter; honours SATURATE_EN when defined.
module tb_twos_comp_arbiter;
    localparam int W = 6;

    typedef struct {
        logic         id;
        logic [W-1:0] data;
        logic         ovf;
    } exp_t;

    logic clk;
    logic rst;
    twos_comp_arbiter_if #(.W(W)) bus();

    twos_comp_arbiter #(.W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   acc_cyc = 0;
    int   exp_lat = 0;
    logic prev_vld = 1'b0;
    exp_t sb[$];
    logic grants[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference computed on integers: true result, then wrap or clamp.
    function automatic logic [W:0] model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        int          ai;
        int          bi;
        int          r;
        logic [31:0] rv;
        logic        ovf;
        logic [W-1:0] d;
        ai = int'($signed(a));
        bi = int'($signed(b));
        case (op)
            2'b00:   r = -ai;
            2'b01:   r = (ai < 0) ? -ai : ai;
            2'b10:   r = ai - bi;
            default: r = ai;
        endcase
        ovf = (r > 31) || (r < -32);
        rv  = r;
        d   = rv[W-1:0];
`ifdef SATURATE_EN
        if (ovf) d = (r > 31) ? 6'b011111 : 6'b100000;
`endif
        return {ovf, d};
    endfunction

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            prev_vld = 1'b0;
        end else begin
            if (bus.req0_ready || bus.req1_ready) begin
                logic     gid;
                logic [W:0] m;
                exp_t     e;
                check_eq("both_ready", {31'd0, bus.req0_ready & bus.req1_ready}, 0);
                check_eq("ready_busy", {31'd0, bus.busy}, 0);
                gid = bus.req1_ready;
                check_eq("ready_valid", {31'd0, gid ? bus.req1_valid : bus.req0_valid}, 1);
                m = gid ? model(bus.req1_op, bus.req1_a, bus.req1_b)
                        : model(bus.req0_op, bus.req0_a, bus.req0_b);
                e.id   = gid;
                e.data = m[W-1:0];
                e.ovf  = m[W];
                sb.push_back(e);
                grants.push_back(gid);
                acc_cyc = cyc;
                exp_lat = ((gid ? bus.req1_op : bus.req0_op) == 2'b10) ? 3 : 2;
            end
            if (bus.rsp_valid && !prev_vld)
                check_eq("latency", cyc - acc_cyc, exp_lat);
            if (bus.rsp_valid && bus.rsp_ready) begin
                if (sb.size() == 0) begin
                    check_eq("sb_underflow", sb.size(), 1);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check_eq("rsp_id",   {31'd0, bus.rsp_id},  {31'd0, e.id});
                    check_eq("rsp_data", {26'd0, bus.rsp_data}, {26'd0, e.data});
                    check_eq("rsp_ovf",  {31'd0, bus.rsp_ovf}, {31'd0, e.ovf});
                end
            end
            prev_vld = bus.rsp_valid;
        end
    end

    task automatic issue(input logic id, input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        int n;
        @(posedge clk); #1;
        if (id) begin
            bus.req1_op = op; bus.req1_a = a; bus.req1_b = b; bus.req1_valid = 1'b1;
        end else begin
            bus.req0_op = op; bus.req0_a = a; bus.req0_b = b; bus.req0_valid = 1'b1;
        end
        n = 0;
        forever begin
            @(negedge clk);
            if (id ? bus.req1_ready : bus.req0_ready) break;
            n++;
            if (n > 200) begin
                check_eq("grant_timeout", 0, 1);
                break;
            end
        end
        @(posedge clk); #1;
        if (id) bus.req1_valid = 1'b0;
        else    bus.req0_valid = 1'b0;
    endtask

    task automatic wait_rsp();
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            if (bus.rsp_valid) break;
            n++;
            if (n > 50) begin
                check_eq("rsp_timeout", 0, 1);
                break;
            end
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            if (!bus.busy && sb.size() == 0) break;
            n++;
            if (n > 100) begin
                check_eq("idle_timeout", 0, 1);
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic         rid;
        logic [1:0]   rop;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        int           n;

        rst = 1'b1;
        bus.req0_valid = 1'b1; bus.req0_op = 2'b00; bus.req0_a = '0; bus.req0_b = '0;
        bus.req1_valid = 1'b0; bus.req1_op = 2'b00; bus.req1_a = '0; bus.req1_b = '0;
        bus.rsp_ready  = 1'b1;
        @(posedge clk); #1;
        check_eq("rst_rsp_valid", {31'd0, bus.rsp_valid}, 0);
        check_eq("rst_busy",      {31'd0, bus.busy}, 0);
        check_eq("rst_rsp_data",  {26'd0, bus.rsp_data}, 0);
        check_eq("rst_rsp_id",    {31'd0, bus.rsp_id}, 0);
        check_eq("rst_rsp_ovf",   {31'd0, bus.rsp_ovf}, 0);
        check_eq("rst_ready0",    {31'd0, bus.req0_ready}, 0);
        bus.req0_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;

        // Reset in the middle of a SUB: work dropped, pointer back to requester 0.
        issue(1'b0, 2'b10, 6'd5, 6'd3);
        @(posedge clk); #1;
        check_eq("sub_exec2_busy", {31'd0, bus.busy}, 1);
        rst = 1'b1;
        #1;
        check_eq("midrst_rsp_valid", {31'd0, bus.rsp_valid}, 0);
        check_eq("midrst_busy",      {31'd0, bus.busy}, 0);
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check_eq("postrst_no_rsp", {31'd0, bus.rsp_valid}, 0);
        end

        // Contention: both held valid, grants must alternate starting at 0.
        grants.delete();
        @(posedge clk); #1;
        bus.req0_op = 2'b11; bus.req0_a = 6'd7; bus.req0_valid = 1'b1;
        bus.req1_op = 2'b11; bus.req1_a = 6'd9; bus.req1_valid = 1'b1;
        n = 0;
        while (grants.size() < 4 && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk); #1;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        check_eq("rr_count", grants.size(), 4);
        for (int i = 0; i < 4 && i < grants.size(); i++)
            check_eq("rr_order", {31'd0, grants[i]}, i % 2);
        wait_idle();

        issue(1'b0, 2'b00, 6'b000101, 6'd0);
        wait_rsp();
        check_eq("neg5_data", {26'd0, bus.rsp_data}, 32'b111011);
        check_eq("neg5_ovf",  {31'd0, bus.rsp_ovf}, 0);
        check_eq("neg5_id",   {31'd0, bus.rsp_id}, 0);
        wait_idle();

        issue(1'b1, 2'b10, 6'b011111, 6'b111111);
        wait_rsp();
`ifdef SATURATE_EN
        check_eq("subovf_data", {26'd0, bus.rsp_data}, 32'b011111);
`else
        check_eq("subovf_data", {26'd0, bus.rsp_data}, 32'b100000);
`endif
        check_eq("subovf_ovf", {31'd0, bus.rsp_ovf}, 1);
        check_eq("subovf_id",  {31'd0, bus.rsp_id}, 1);
        wait_idle();

        issue(1'b0, 2'b01, 6'b100000, 6'd0);
        wait_rsp();
`ifdef SATURATE_EN
        check_eq("absmin_data", {26'd0, bus.rsp_data}, 32'b011111);
`else
        check_eq("absmin_data", {26'd0, bus.rsp_data}, 32'b100000);
`endif
        check_eq("absmin_ovf", {31'd0, bus.rsp_ovf}, 1);
        wait_idle();

        issue(1'b0, 2'b01, 6'b110000, 6'd0);
        wait_rsp();
        check_eq("absm16_data", {26'd0, bus.rsp_data}, 32'b010000);
        check_eq("absm16_ovf",  {31'd0, bus.rsp_ovf}, 0);
        wait_idle();

        // B = most negative value, both signs of A, plus NEG of the minimum.
        issue(1'b1, 2'b10, 6'd3, 6'b100000);
        issue(1'b0, 2'b10, 6'b111111, 6'b100000);
        issue(1'b1, 2'b00, 6'b100000, 6'd0);
        issue(1'b0, 2'b10, 6'b100000, 6'd1);
        wait_idle();

        for (int i = 0; i < 24; i++) begin
            rid = 1'($urandom_range(0, 1));
            rop = 2'($urandom_range(0, 3));
            ra  = 6'($urandom);
            rb  = 6'($urandom);
            issue(rid, rop, ra, rb);
        end
        wait_idle();

        // Backpressure: response held, no grants until the handshake retires it.
        bus.rsp_ready = 1'b0;
        issue(1'b0, 2'b00, 6'd1, 6'd0);
        bus.req1_op = 2'b11; bus.req1_a = 6'd2; bus.req1_b = 6'd0; bus.req1_valid = 1'b1;
        wait_rsp();
        repeat (5) begin
            @(negedge clk);
            check_eq("bp_valid",  {31'd0, bus.rsp_valid}, 1);
            check_eq("bp_data",   {26'd0, bus.rsp_data}, 32'b111111);
            check_eq("bp_ready0", {31'd0, bus.req0_ready}, 0);
            check_eq("bp_ready1", {31'd0, bus.req1_ready}, 0);
        end
        @(posedge clk); #1;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        check_eq("hs_cycle_ready1", {31'd0, bus.req1_ready}, 0);
        @(negedge clk);
        check_eq("next_grant_ready1", {31'd0, bus.req1_ready}, 1);
        @(posedge clk); #1;
        bus.req1_valid = 1'b0;
        wait_idle();

        check_eq("sb_leftover", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
